// File: rtl/int_sched.sv
`default_nettype none
// ============================================================================
// Module      : int_sched
// Description : Interrupt scheduler that injects one interrupt at a time into
//               the IF/ID pipeline register. External requests are latched
//               into a pending vector and qualified by the global and
//               per-source enables. The lowest eligible index wins and is
//               presented to IF/ID until IF/ID samples it (lock low). The
//               scheduler then captures EPC and blocks further interrupts
//               until eret. There is no nesting and no preemption.
//
//               Optional build macro:
//                 INT_EDGE_DETECT_EN : sticky rising-edge pending bits,
//                                      cleared on accept. When undefined,
//                                      pending follows the irq level.
//
// Parameters  : NUM_SRC  number of request lines (1..4)
//               PC_W     width of PC / EPC
// Ports       : clk          system clock, rising edge
//               rst          asynchronous active-low reset
//               irq          raw interrupt request lines
//               ie_mask      per-source interrupt enable
//               gie          global interrupt enable
//               lock         IF/ID stall (IF/ID samples when lock = 0)
//               pc_if        PC entering IF/ID, captured as EPC on accept
//               eret         return-from-interrupt pulse from ID
//               int_trigger  interrupt request to IF/ID
//               which_int    selected source index to IF/ID
//               epc          captured return PC
//               in_service   handler active
//               pending      pending-request vector
// Revision    : 1.0  initial release
// ============================================================================
module int_sched #(
    parameter int NUM_SRC = 3,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq,
    input  logic [NUM_SRC-1:0] ie_mask,
    input  logic               gie,
    input  logic               lock,
    input  logic [PC_W-1:0]    pc_if,
    input  logic               eret,
    output logic               int_trigger,
    output logic [1:0]         which_int,
    output logic [PC_W-1:0]    epc,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_SRC-1:0] r_pending;
    logic [1:0]         r_which_int;
    logic [PC_W-1:0]    r_epc;
    logic               r_in_service;

    logic [NUM_SRC-1:0] w_eligible;
    logic [1:0]         w_win_idx;
    logic [3:0]         w_mask_ext;
    logic               w_cur_en;
    logic               w_accept;

    assign w_eligible = r_pending & ie_mask & {NUM_SRC{gie}};

    // Fixed priority: scan from the top so the lowest set index is left last.
    always_comb begin
        w_win_idx = 2'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win_idx = 2'(i);
            end
        end
    end

    // Zero-extended mask so the 2-bit source index never selects out of range.
    always_comb begin
        w_mask_ext                = 4'd0;
        w_mask_ext[NUM_SRC-1:0]   = ie_mask;
    end

    assign w_cur_en = gie & w_mask_ext[r_which_int];

    // IF/ID samples only when lock is low, so an accept is exactly a trigger
    // cycle in ARMED.
    assign w_accept = (r_state == S_ARMED) & ~lock;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_which_int  <= 2'd0;
            r_epc        <= '0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_eligible) begin
                        r_state     <= S_ARMED;
                        r_which_int <= w_win_idx;
                    end
                end
                S_ARMED: begin
                    // Accept wins over an abort in the same cycle: IF/ID has
                    // already taken the interrupt.
                    if (!lock) begin
                        r_state      <= S_SERVICE;
                        r_epc        <= pc_if;
                        r_in_service <= 1'b1;
                    end else if (!w_cur_en) begin
                        r_state <= S_IDLE;
                    end
                end
                S_SERVICE: begin
                    if (eret) begin
                        r_state      <= S_IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pending vector
    // ------------------------------------------------------------------
`ifdef INT_EDGE_DETECT_EN
    logic [NUM_SRC-1:0] r_irq_prev;
    logic [NUM_SRC-1:0] w_rise;
    logic [3:0]         w_clr_ext;
    logic [NUM_SRC-1:0] w_clr;

    assign w_rise    = irq & ~r_irq_prev;
    assign w_clr_ext = w_accept ? (4'b0001 << r_which_int) : 4'b0000;
    assign w_clr     = w_clr_ext[NUM_SRC-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
        end else begin
            r_irq_prev <= irq;
            // A fresh edge on the source being cleared keeps its bit set.
            r_pending  <= (r_pending & ~w_clr) | w_rise;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= irq;
        end
    end
`endif

    assign int_trigger = w_accept;
    assign which_int   = r_which_int;
    assign epc         = r_epc;
    assign in_service  = r_in_service;
    assign pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_int_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_sched
// Description : Directed self-checking bench for int_sched. Inputs change 1 ns
//               after the rising edge; outputs are sampled at that point.
//               Covers both pending modes via INT_EDGE_DETECT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_int_sched;

    localparam int NUM_SRC = 3;
    localparam int PC_W    = 32;

    logic               clk;
    logic               rst;
    logic [NUM_SRC-1:0] irq;
    logic [NUM_SRC-1:0] ie_mask;
    logic               gie;
    logic               lock;
    logic [PC_W-1:0]    pc_if;
    logic               eret;
    logic               int_trigger;
    logic [1:0]         which_int;
    logic [PC_W-1:0]    epc;
    logic               in_service;
    logic [NUM_SRC-1:0] pending;

    int n_vec;
    int n_err;

    int_sched #(
        .NUM_SRC (NUM_SRC),
        .PC_W    (PC_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq),
        .ie_mask     (ie_mask),
        .gie         (gie),
        .lock        (lock),
        .pc_if       (pc_if),
        .eret        (eret),
        .int_trigger (int_trigger),
        .which_int   (which_int),
        .epc         (epc),
        .in_service  (in_service),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst  = 1'b0;
        irq  = '0;
        eret = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b0;
        irq     = '0;
        ie_mask = 3'b111;
        gie     = 1'b1;
        lock    = 1'b0;
        pc_if   = '0;
        eret    = 1'b0;

        // Reset values
        step();
        step();
        chk("rst_trig",    64'(int_trigger), 64'd0);
        chk("rst_which",   64'(which_int),   64'd0);
        chk("rst_epc",     64'(epc),         64'd0);
        chk("rst_insvc",   64'(in_service),  64'd0);
        chk("rst_pending", 64'(pending),     64'd0);
        rst = 1'b1;
        step();

        // Single request on source 1, no stall
        irq   = 3'b010;
        pc_if = 32'h0000_0040;
        step();
        chk("s1_pending", 64'(pending),     64'h2);
        chk("s1_trig0",   64'(int_trigger), 64'd0);
        irq = '0;
        step();
        chk("s1_trig1",   64'(int_trigger), 64'd1);
        chk("s1_which",   64'(which_int),   64'd1);
        step();
        chk("s1_trig2",   64'(int_trigger), 64'd0);
        chk("s1_epc",     64'(epc),         64'h40);
        chk("s1_insvc",   64'(in_service),  64'd1);
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("eret_insvc", 64'(in_service),  64'd0);
        chk("eret_trig",  64'(int_trigger), 64'd0);
        step();
        chk("idle_trig",  64'(int_trigger), 64'd0);

        // Stall hold on source 2; source 0 arrives while armed
        reset_dut();
        lock  = 1'b1;
        irq   = 3'b100;
        pc_if = 32'h0000_0080;
        step();
        step();
        chk("st_which0", 64'(which_int),   64'd2);
        chk("st_trig0",  64'(int_trigger), 64'd0);
        irq = 3'b101;
        step();
        chk("st_which1", 64'(which_int),   64'd2);
        chk("st_trig1",  64'(int_trigger), 64'd0);
        step();
        chk("st_which2", 64'(which_int),   64'd2);
        chk("st_trig2",  64'(int_trigger), 64'd0);
        lock = 1'b0;
        irq  = '0;
        #1;
        chk("st_trig_go",  64'(int_trigger), 64'd1);
        chk("st_which_go", 64'(which_int),   64'd2);
        step();
        chk("st_trig_svc", 64'(int_trigger), 64'd0);
        chk("st_insvc",    64'(in_service),  64'd1);
        chk("st_epc",      64'(epc),         64'h80);
        chk("st_which_sv", 64'(which_int),   64'd2);

        // Asynchronous reset while in service
        rst = 1'b0;
        #1;
        chk("arst_trig",    64'(int_trigger), 64'd0);
        chk("arst_which",   64'(which_int),   64'd0);
        chk("arst_epc",     64'(epc),         64'd0);
        chk("arst_insvc",   64'(in_service),  64'd0);
        chk("arst_pending", 64'(pending),     64'd0);
        step();
        rst = 1'b1;
        step();
        chk("arst_idle_trig",  64'(int_trigger), 64'd0);
        chk("arst_idle_insvc", 64'(in_service),  64'd0);

        // Simultaneous requests: lowest index wins
        irq   = 3'b101;
        pc_if = 32'h0000_00C0;
        step();
        irq = '0;
        step();
        chk("pri_which", 64'(which_int),   64'd0);
        chk("pri_trig",  64'(int_trigger), 64'd1);
        step();
        chk("pri_epc",   64'(epc),         64'hC0);
        chk("pri_insvc", 64'(in_service),  64'd1);
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("pri_eret", 64'(in_service), 64'd0);

        // Abort by dropping gie while armed
        reset_dut();
        lock = 1'b1;
        irq  = 3'b010;
        step();
        irq = '0;
        step();
        chk("ab_which", 64'(which_int),   64'd1);
        chk("ab_trig",  64'(int_trigger), 64'd0);
        gie = 1'b0;
        step();
        lock = 1'b0;
        #1;
        chk("ab_trig_idle", 64'(int_trigger), 64'd0);
        step();
        chk("ab_insvc", 64'(in_service), 64'd0);

        // Masked source never arms
        ie_mask = 3'b101;
        gie     = 1'b1;
        irq     = 3'b010;
        step();
        step();
        step();
        chk("mk_trig",    64'(int_trigger), 64'd0);
        chk("mk_insvc",   64'(in_service),  64'd0);
        chk("mk_pending", 64'(pending),     64'h2);
        reset_dut();
        ie_mask = 3'b111;

        // Source 0 held high across a full service
        irq   = 3'b001;
        lock  = 1'b0;
        pc_if = 32'h0000_0100;
        step();
        step();
        chk("hold_trig",  64'(int_trigger), 64'd1);
        chk("hold_which", 64'(which_int),   64'd0);
        step();
        chk("hold_epc",   64'(epc),         64'h100);
        chk("hold_insvc", 64'(in_service),  64'd1);
        step();
        chk("hold_svc_trig", 64'(int_trigger), 64'd0);
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("hold_eret_insvc", 64'(in_service),  64'd0);
        chk("hold_eret_trig",  64'(int_trigger), 64'd0);
        step();
`ifdef INT_EDGE_DETECT_EN
        chk("edge_no_retrig0", 64'(int_trigger), 64'd0);
        step();
        chk("edge_no_retrig1", 64'(int_trigger), 64'd0);
        chk("edge_insvc",      64'(in_service),  64'd0);
`else
        chk("lvl_retrig",       64'(int_trigger), 64'd1);
        chk("lvl_retrig_which", 64'(which_int),   64'd0);
        irq = '0;
        step();
        chk("lvl_retrig_insvc", 64'(in_service), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
